// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the add/sub accumulator sequencer.
// Holds the opcode and FSM state encodings plus the signed-overflow helper.
package addsub_seq_pkg;

  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_ADD   = 2'd2,
    OP_SUB   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Two's-complement overflow from the sign bits of accumulator, operand and result.
  function automatic logic signed_ovf(input logic a, input logic b, input logic r,
                                      input logic sub);
    if (sub) begin
      return (a != b) && (r != a);
    end
    return (a == b) && (r != a);
  endfunction

endpackage

// File: rtl/four_bit_adder_subtractor.sv
// Existing 4-bit adder/subtractor: Result = A + B, or A + ~B + 1 when subtract is set.
// Cout is the raw carry out of the 4-bit addition in both modes.
module four_bit_adder_subtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       subtract,
  output logic [3:0] Result,
  output logic       Cout
);

  logic [3:0] b_eff;

  assign b_eff = B ^ {4{subtract}};
  assign {Cout, Result} = {1'b0, A} + {1'b0, b_eff} + {4'b0000, subtract};

endmodule

// File: rtl/addsub_sequencer.sv
// Single-command accumulator sequencer (IDLE -> EXEC -> RESP) with valid/ready handshakes.
// Optional signed overflow output is enabled by defining ADDSUB_OVF_EN.
module addsub_sequencer
  import addsub_seq_pkg::*;
#(
  parameter logic [DATA_W-1:0] ACC_RST_VAL = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_cout,
  output logic              out_zero
`ifdef ADDSUB_OVF_EN
  ,
  output logic              out_ovf
`endif
);

  state_e            state_q;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] acc_q;
  logic              cout_q;
  logic              valid_q;
  logic              ready_q;
  logic [DATA_W-1:0] sum;
  logic              sum_cout;
  logic              is_sub;
`ifdef ADDSUB_OVF_EN
  logic              ovf_q;
`endif

  assign is_sub = (op_q == OP_SUB);

  four_bit_adder_subtractor u_addsub (
    .A        (acc_q),
    .B        (data_q),
    .subtract (is_sub),
    .Result   (sum),
    .Cout     (sum_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_CLEAR;
      data_q  <= '0;
      acc_q   <= ACC_RST_VAL;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && ready_q) begin
            op_q    <= op_e'(in_op);
            data_q  <= in_data;
            ready_q <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          unique case (op_q)
            OP_CLEAR: begin
              acc_q  <= '0;
              cout_q <= 1'b0;
            end
            OP_LOAD: begin
              acc_q  <= data_q;
              cout_q <= 1'b0;
            end
            OP_ADD, OP_SUB: begin
              acc_q  <= sum;
              cout_q <= sum_cout;
            end
          endcase
`ifdef ADDSUB_OVF_EN
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            ovf_q <= signed_ovf(acc_q[DATA_W-1], data_q[DATA_W-1], sum[DATA_W-1], is_sub);
          end else begin
            ovf_q <= 1'b0;
          end
`endif
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          // Result registers are only written in EXEC, so they hold here until the handshake.
          if (out_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_result = acc_q;
  assign out_cout   = cout_q;
  assign out_zero   = (acc_q == '0);
`ifdef ADDSUB_OVF_EN
  assign out_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed self-checking bench for addsub_sequencer, including backpressure and mid-op reset.
// Build with ADDSUB_OVF_EN defined to also check out_ovf.
module tb_addsub_sequencer;

  localparam logic [3:0] RST_VAL = 4'h3;
  localparam logic [1:0] C_CLEAR = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_ADD   = 2'd2;
  localparam logic [1:0] C_SUB   = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_cout;
  logic       out_zero;
`ifdef ADDSUB_OVF_EN
  logic       out_ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_sequencer #(
    .ACC_RST_VAL (RST_VAL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_zero   (out_zero)
`ifdef ADDSUB_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  // One command with out_ready high: check accept, response 2 cycles later, return to IDLE.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input logic [3:0] er,
                        input logic ec, input logic eovf, input string nm);
    int   n;
    logic got_ovf;
    logic [7:0] got;
    logic [7:0] exp;
    @(negedge clk);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: in_ready=%b required 1", nm, in_ready);
    end
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_exec: out_valid=%b in_ready=%b required 0 0", nm, out_valid, in_ready);
    end
    @(posedge clk);
    #1;
`ifdef ADDSUB_OVF_EN
    got_ovf = out_ovf;
`else
    got_ovf = eovf;
`endif
    got = {out_valid, out_result, out_cout, out_zero, got_ovf};
    exp = {1'b1, er, ec, (er == 4'h0), eovf};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_resp: {valid,result,cout,zero,ovf}=%b required %b", nm, got, exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: out_valid=%b in_ready=%b required 0 1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_data   = 4'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== RST_VAL) begin
      errors++;
      $display("FAIL reset_hold: out_valid=%b out_result=%h required 0 %h",
               out_valid, out_result, RST_VAL);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_result, out_cout, out_zero} !== {2'b10, RST_VAL, 2'b00}) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b result=%h cout=%b zero=%b required 1 0 %h 0 0",
               in_ready, out_valid, out_result, out_cout, out_zero, RST_VAL);
    end
  endtask

  task automatic test_basic();
    do_cmd(C_LOAD, 4'h1, 4'h1, 1'b0, 1'b0, "load1");
    do_cmd(C_ADD,  4'h0, 4'h1, 1'b0, 1'b0, "add0");
  endtask

  task automatic test_sub_add();
    do_cmd(C_LOAD, 4'h9, 4'h9, 1'b0, 1'b0, "load9");
    do_cmd(C_SUB,  4'h2, 4'h7, 1'b1, 1'b1, "sub2");
    do_cmd(C_ADD,  4'h3, 4'hA, 1'b0, 1'b1, "add3");
  endtask

  task automatic test_wrap();
    do_cmd(C_LOAD, 4'h2, 4'h2, 1'b0, 1'b0, "load2");
    do_cmd(C_SUB,  4'h3, 4'hF, 1'b0, 1'b0, "sub3_wrap");
    do_cmd(C_ADD,  4'h1, 4'h0, 1'b1, 1'b0, "add1_wrap");
    do_cmd(C_LOAD, 4'h8, 4'h8, 1'b0, 1'b0, "load8");
    do_cmd(C_ADD,  4'h8, 4'h0, 1'b1, 1'b1, "add8_ovf");
    do_cmd(C_SUB,  4'h0, 4'h0, 1'b1, 1'b0, "sub0_eq");
  endtask

  task automatic test_clear();
    do_cmd(C_LOAD,  4'h5, 4'h5, 1'b0, 1'b0, "load5");
    do_cmd(C_CLEAR, 4'h7, 4'h0, 1'b0, 1'b0, "clear");
  endtask

  task automatic test_backpressure();
    do_cmd(C_LOAD, 4'h5, 4'h5, 1'b0, 1'b0, "bp_load5");
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = C_ADD;
    in_data   = 4'h3;
    @(posedge clk);
    #1;
    // Keep presenting a different command; it must wait for IDLE.
    in_op   = C_SUB;
    in_data = 4'h1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready, out_valid, out_result, out_cout, out_zero} !== {2'b01, 4'h8, 2'b00}) begin
        errors++;
        $display("FAIL bp_stall%0d: ready=%b valid=%b result=%h cout=%b zero=%b required 0 1 8 0 0",
                 i, in_ready, out_valid, out_result, out_cout, out_zero);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_result} !== {2'b10, 4'h8}) begin
      errors++;
      $display("FAIL bp_release: ready=%b valid=%b result=%h required 1 0 8",
               in_ready, out_valid, out_result);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: ready=%b valid=%b required 0 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_result, out_cout} !== {1'b1, 4'h7, 1'b1}) begin
      errors++;
      $display("FAIL bp_pending: valid=%b result=%h cout=%b required 1 7 1",
               out_valid, out_result, out_cout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    do_cmd(C_LOAD, 4'h4, 4'h4, 1'b0, 1'b0, "rst_load4");
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = C_ADD;
    in_data  = 4'h1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_result} !== {2'b01, RST_VAL}) begin
      errors++;
      $display("FAIL rst_mid: valid=%b ready=%b result=%h required 0 1 %h",
               out_valid, in_ready, out_result, RST_VAL);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_after%0d: valid=%b ready=%b required 0 1", i, out_valid, in_ready);
      end
    end
    do_cmd(C_ADD, 4'h2, 4'h5, 1'b0, 1'b0, "rst_add2");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sub_add();
    test_wrap();
    test_clear();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
